// File: rtl/i2c_frame_monitor_if.sv
// Bus and status bundle for the passive I2C frame monitor.
// The monitor owns the "master" view: it reads the bus lines and drives the
// decoded status. The "slave" view belongs to whatever drives the bus lines
// and consumes the status (generator side / status logic / bench).
interface i2c_frame_monitor_if #(
    parameter int CNT_W = 4
);
    logic             scl_in;
    logic             sda_in;
    logic             start_det;
    logic             stop_det;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ack;
    logic             byte_first;
    logic             frame_done;
    logic [CNT_W-1:0] frame_bytes;
    logic             err_partial;
    logic             err_timeout;
    logic             busy;

    modport master (
        input  scl_in,
        input  sda_in,
        output start_det,
        output stop_det,
        output byte_valid,
        output byte_data,
        output byte_ack,
        output byte_first,
        output frame_done,
        output frame_bytes,
        output err_partial,
        output err_timeout,
        output busy
    );

    modport slave (
        output scl_in,
        output sda_in,
        input  start_det,
        input  stop_det,
        input  byte_valid,
        input  byte_data,
        input  byte_ack,
        input  byte_first,
        input  frame_done,
        input  frame_bytes,
        input  err_partial,
        input  err_timeout,
        input  busy
    );
endinterface

// File: rtl/i2c_frame_monitor.sv
// Passive I2C frame decoder. Synchronises SCL/SDA into clk_in, detects
// START/STOP/SCL rises, assembles bytes plus ACK bit, and summarises each
// frame (byte count, partial-byte and stall errors). Never drives the bus.
module i2c_frame_monitor #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 4
) (
    input  logic                clk_in,
    input  logic                reset_in,
    i2c_frame_monitor_if.master mon
);

    // Fewer than two synchroniser flops would not be metastability safe.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ACK
    } state_t;

    // Synchroniser chains and one-cycle-delayed copies of their outputs.
    logic [SYNC_N-1:0] scl_sync_q;
    logic [SYNC_N-1:0] sda_sync_q;
    logic              scl_p_q;
    logic              sda_p_q;
    logic              scl_s;
    logic              sda_s;

    // Decoder state.
    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              first_q, first_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    // Registered outputs.
    logic              start_det_q, start_det_d;
    logic              stop_det_q, stop_det_d;
    logic              byte_valid_q, byte_valid_d;
    logic [7:0]        byte_data_q, byte_data_d;
    logic              byte_ack_q, byte_ack_d;
    logic              byte_first_q, byte_first_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_W-1:0]  frame_bytes_q, frame_bytes_d;
    logic              err_partial_q, err_partial_d;
    logic              err_timeout_q, err_timeout_d;
    logic              busy_q, busy_d;

    // Bus events seen in the synchronised domain.
    logic              start_c;
    logic              stop_c;
    logic              scl_rise;
    logic              scl_fall;
    logic              partial_c;

    assign scl_s = scl_sync_q[SYNC_N-1];
    assign sda_s = sda_sync_q[SYNC_N-1];

    // SDA may only count as START/STOP while SCL is stable high in both samples,
    // so a simultaneous SCL edge can never be mistaken for a condition.
    assign start_c  = scl_p_q & scl_s & sda_p_q & ~sda_s;
    assign stop_c   = scl_p_q & scl_s & ~sda_p_q & sda_s;
    assign scl_rise = ~scl_p_q & scl_s;
    assign scl_fall = scl_p_q & ~scl_s;

    // A frame cut short is "partial" when any bit of the current byte arrived.
    assign partial_c = (state_q == ST_ACK) ||
                       ((state_q == ST_DATA) && (bit_cnt_q != 3'd0));

    // Synchronise the asynchronous bus lines; reset to the idle-bus level.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_N-2:0], mon.scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_N-2:0], mon.sda_in};
            scl_p_q    <= scl_s;
            sda_p_q    <= sda_s;
        end
    end

    // Decoder state and output registers.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            cnt_q         <= '0;
            first_q       <= 1'b0;
            timer_q       <= '0;
            start_det_q   <= 1'b0;
            stop_det_q    <= 1'b0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= '0;
            byte_ack_q    <= 1'b0;
            byte_first_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_bytes_q <= '0;
            err_partial_q <= 1'b0;
            err_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            first_q       <= first_d;
            timer_q       <= timer_d;
            start_det_q   <= start_det_d;
            stop_det_q    <= stop_det_d;
            byte_valid_q  <= byte_valid_d;
            byte_data_q   <= byte_data_d;
            byte_ack_q    <= byte_ack_d;
            byte_first_q  <= byte_first_d;
            frame_done_q  <= frame_done_d;
            frame_bytes_q <= frame_bytes_d;
            err_partial_q <= err_partial_d;
            err_timeout_q <= err_timeout_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state and output decode: STOP/START first, then SCL activity, stall last.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        first_d       = first_q;
        timer_d       = timer_q;
        start_det_d   = 1'b0;
        stop_det_d    = 1'b0;
        byte_valid_d  = 1'b0;
        byte_data_d   = byte_data_q;
        byte_ack_d    = byte_ack_q;
        byte_first_d  = byte_first_q;
        frame_done_d  = 1'b0;
        frame_bytes_d = frame_bytes_q;
        err_partial_d = 1'b0;
        err_timeout_d = 1'b0;
        busy_d        = busy_q;

        if (stop_c) begin
            stop_det_d = 1'b1;
            timer_d    = '0;
            if (state_q != ST_IDLE) begin
                frame_done_d  = 1'b1;
                frame_bytes_d = cnt_q;
                err_partial_d = partial_c;
                busy_d        = 1'b0;
                state_d       = ST_IDLE;
            end
        end else if (start_c) begin
            // Plain or repeated START; a repeated one also closes the old frame.
            start_det_d = 1'b1;
            timer_d     = '0;
            if (state_q != ST_IDLE) begin
                frame_done_d  = 1'b1;
                frame_bytes_d = cnt_q;
                err_partial_d = partial_c;
            end
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            cnt_d     = '0;
            first_d   = 1'b1;
            busy_d    = 1'b1;
        end else if (state_q != ST_IDLE) begin
            if (scl_rise || scl_fall) begin
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end

            if (scl_rise) begin
                if (state_q == ST_DATA) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_ACK;
                    end
                end else begin
                    byte_valid_d = 1'b1;
                    byte_data_d  = shift_q;
                    byte_ack_d   = ~sda_s;
                    byte_first_d = first_q;
                    first_d      = 1'b0;
                    cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    bit_cnt_d    = '0;
                    state_d      = ST_DATA;
                end
            end else if (!scl_fall && (timer_q == TMR_LAST)) begin
                // SCL stalled: close the frame with the complete bytes only.
                err_timeout_d = 1'b1;
                frame_done_d  = 1'b1;
                frame_bytes_d = cnt_q;
                busy_d        = 1'b0;
                timer_d       = '0;
                bit_cnt_d     = '0;
                state_d       = ST_IDLE;
            end
        end else begin
            timer_d = '0;
        end
    end

    assign mon.start_det   = start_det_q;
    assign mon.stop_det    = stop_det_q;
    assign mon.byte_valid  = byte_valid_q;
    assign mon.byte_data   = byte_data_q;
    assign mon.byte_ack    = byte_ack_q;
    assign mon.byte_first  = byte_first_q;
    assign mon.frame_done  = frame_done_q;
    assign mon.frame_bytes = frame_bytes_q;
    assign mon.err_partial = err_partial_q;
    assign mon.err_timeout = err_timeout_q;
    assign mon.busy        = busy_q;

endmodule

// File: tb/tb_i2c_frame_monitor.sv
// Bench for i2c_frame_monitor: drives I2C bus waveforms, predicts every
// output event (with its cycle) from bus-level rules, and compares in order.
module tb_i2c_frame_monitor;

    localparam int S    = 2;
    localparam int T    = 64;
    localparam int CW   = 4;
    localparam int BMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    i2c_frame_monitor_if #(.CNT_W(CW)) bus ();

    i2c_frame_monitor #(
        .SYNC_STAGES    (S),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (CW)
    ) dut (
        .clk_in   (clk),
        .reset_in (rst_n),
        .mon      (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: observed no end by time %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int       cyc;
        bit       st, sp, bv;
        bit [7:0] data;
        bit       ack, first, fd;
        int       fb;
        bit       ep, et, busy;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];
    ev_t mon_ev;
    int  n_cmp = 0;
    int  n_err = 0;

    // Reference model: what the bus has carried so far in the current frame.
    bit       in_frame = 0;
    int       nbits    = 0;
    int       nbytes   = 0;
    bit [7:0] sh       = 0;
    bit       first_m  = 0;
    int       last_clr = 0;

    logic scl_r = 1'b1;
    logic sda_r = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        if (obs !== req) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
        end
    endtask

    // Capture every cycle that carries a pulse, away from the active edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (bus.start_det === 1'b1 || bus.stop_det === 1'b1 || bus.byte_valid === 1'b1 ||
            bus.frame_done === 1'b1 || bus.err_partial === 1'b1 || bus.err_timeout === 1'b1) begin
            mon_ev.cyc   = cyc;
            mon_ev.st    = bus.start_det;
            mon_ev.sp    = bus.stop_det;
            mon_ev.bv    = bus.byte_valid;
            mon_ev.data  = bus.byte_data;
            mon_ev.ack   = bus.byte_ack;
            mon_ev.first = bus.byte_first;
            mon_ev.fd    = bus.frame_done;
            mon_ev.fb    = int'(bus.frame_bytes);
            mon_ev.ep    = bus.err_partial;
            mon_ev.et    = bus.err_timeout;
            mon_ev.busy  = bus.busy;
            got_q.push_back(mon_ev);
        end
    end

    function automatic ev_t blank(input int c);
        ev_t e;
        e     = '{default: 0};
        e.cyc = c;
        return e;
    endfunction

    // A change on the bus at cycle c shows up on the outputs S+1 edges later.
    function automatic void model_rise(input bit b, input int c);
        ev_t e;
        if (!in_frame) return;
        nbits++;
        if (nbits <= 8) begin
            sh = {sh[6:0], b};
        end else begin
            e       = blank(c + S + 1);
            e.bv    = 1;
            e.data  = sh;
            e.ack   = !b;
            e.first = first_m;
            e.busy  = 1;
            exp_q.push_back(e);
            first_m = 0;
            if (nbytes < BMAX) nbytes++;
            nbits = 0;
        end
    endfunction

    function automatic void model_start(input int c);
        ev_t e;
        e      = blank(c + S + 1);
        e.st   = 1;
        e.busy = 1;
        if (in_frame) begin
            e.fd = 1;
            e.fb = nbytes;
            e.ep = (nbits != 0);
        end
        exp_q.push_back(e);
        in_frame = 1;
        nbits    = 0;
        nbytes   = 0;
        first_m  = 1;
    endfunction

    function automatic void model_stop(input int c);
        ev_t e;
        e    = blank(c + S + 1);
        e.sp = 1;
        if (in_frame) begin
            e.fd = 1;
            e.fb = nbytes;
            e.ep = (nbits != 0);
        end
        exp_q.push_back(e);
        in_frame = 0;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_scl(input logic v);
        @(posedge clk);
        #2;
        if (v !== scl_r) begin
            last_clr = cyc;
            if (v) model_rise(sda_r, cyc);
        end
        scl_r      = v;
        bus.scl_in = v;
    endtask

    task automatic set_sda(input logic v);
        @(posedge clk);
        #2;
        if (v !== sda_r && scl_r) begin
            last_clr = cyc;
            if (v) model_stop(cyc);
            else   model_start(cyc);
        end
        sda_r      = v;
        bus.sda_in = v;
    endtask

    task automatic send_bit(input logic b);
        set_scl(1'b0);
        idle($urandom_range(3, 10));
        set_sda(b);
        idle($urandom_range(3, 10));
        set_scl(1'b1);
        idle($urandom_range(8, 20));
    endtask

    task automatic send_byte(input logic [7:0] d, input logic ack_lvl);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(ack_lvl);
    endtask

    task automatic send_start();
        if (scl_r && sda_r) begin
            set_sda(1'b0);
        end else begin
            if (scl_r) set_scl(1'b0);
            idle(5);
            set_sda(1'b1);
            idle(5);
            set_scl(1'b1);
            idle(10);
            set_sda(1'b0);
        end
        idle(15);
    endtask

    task automatic send_stop();
        if (scl_r && !sda_r) begin
            set_sda(1'b1);
        end else begin
            if (scl_r) set_scl(1'b0);
            idle(5);
            set_sda(1'b0);
            idle(5);
            set_scl(1'b1);
            idle(10);
            set_sda(1'b1);
        end
        idle(20);
    endtask

    // Hold SCL low until the monitor gives up on the frame.
    task automatic stall();
        ev_t e;
        set_scl(1'b0);
        if (in_frame) begin
            e      = blank(last_clr + S + 1 + T);
            e.fd   = 1;
            e.et   = 1;
            e.fb   = nbytes;
            exp_q.push_back(e);
            in_frame = 0;
        end
        idle(T + 30);
    endtask

    task automatic compare_events(input string name);
        ev_t g, e;
        int  n;
        idle(40);
        check_eq({name, " count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            g = got_q[i];
            e = exp_q[i];
            $display("[%s] cyc=%0d st=%0b sp=%0b bv=%0b data=%02h ack=%0b first=%0b fd=%0b fb=%0d ep=%0b et=%0b busy=%0b",
                     name, g.cyc, g.st, g.sp, g.bv, g.data, g.ack, g.first, g.fd, g.fb, g.ep, g.et, g.busy);
            check_eq({name, " cyc"}, g.cyc, e.cyc);
            check_eq({name, " flags"}, {g.st, g.sp, g.bv, g.fd, g.ep, g.et, g.busy},
                                       {e.st, e.sp, e.bv, e.fd, e.ep, e.et, e.busy});
            if (e.bv) begin
                check_eq({name, " data"},  g.data,  e.data);
                check_eq({name, " ack"},   g.ack,   e.ack);
                check_eq({name, " first"}, g.first, e.first);
            end
            if (e.fd) check_eq({name, " frame_bytes"}, g.fb, e.fb);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic hard_reset_bus();
        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;
        scl_r      = 1'b1;
        sda_r      = 1'b1;
        in_frame   = 0;
        nbits      = 0;
        nbytes     = 0;
    endtask

    initial begin
        logic [7:0] d;
        int         nb;
        int         pb;
        bit         by_stall;

        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;

        // Reset with a toggling bus: every output must stay 0.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_outs", {bus.start_det, bus.stop_det, bus.byte_valid, bus.byte_data,
                                  bus.byte_ack, bus.byte_first, bus.frame_done, bus.frame_bytes,
                                  bus.err_partial, bus.err_timeout, bus.busy}, 32'd0);
            #1;
            bus.scl_in = 1'(($urandom));
            bus.sda_in = 1'(($urandom));
        end
        hard_reset_bus();
        idle(3);
        #2;
        rst_n = 1'b1;
        compare_events("reset_release");

        // START, 0x40/0x01/0xF9 all ACKed, STOP.
        send_start();
        send_byte(8'h40, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hF9, 1'b0);
        send_stop();
        compare_events("three_bytes");

        // NACKed byte.
        send_start();
        send_byte(8'hA5, 1'b1);
        send_stop();
        compare_events("nack");

        // Frame ending after three bits.
        send_start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_stop();
        compare_events("partial");

        // Repeated START between two single-byte frames.
        send_start();
        send_byte(8'h40, 1'b0);
        send_start();
        send_byte(8'h41, 1'b0);
        send_stop();
        compare_events("rep_start");

        // SCL stall after two bits, then a STOP on an idle monitor.
        send_start();
        send_bit(1'b0);
        send_bit(1'b1);
        stall();
        #1;
        check_eq("timeout_busy", bus.busy, 1'b0);
        send_stop();
        compare_events("timeout");

        // Byte counter saturation.
        send_start();
        for (int i = 0; i < BMAX + 2; i++) send_byte(8'(i * 7 + 3), 1'b0);
        send_stop();
        compare_events("saturate");

        // Randomised frames.
        for (int f = 0; f < 10; f++) begin
            send_start();
            nb = $urandom_range(0, 5);
            for (int i = 0; i < nb; i++) begin
                d = 8'($urandom);
                send_byte(d, 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 2) == 0) begin
                send_start();
                d = 8'($urandom);
                send_byte(d, 1'($urandom_range(0, 1)));
            end
            pb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
            for (int i = 0; i < pb; i++) send_bit(1'($urandom_range(0, 1)));
            by_stall = ($urandom_range(0, 3) == 0);
            if (by_stall) stall();
            send_stop();
            compare_events("random");
        end

        // Reset in the middle of a byte: partial state vanishes silently.
        send_start();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        hard_reset_bus();
        idle(4);
        #1;
        check_eq("rst_mid_busy", bus.busy, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        compare_events("reset_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
